// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART TX scheduler: FSM state encoding,
// byte width and the index-width helper used to size requester indices.
package uart_sched_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker. The request vector is rotated so that
// the slot after ptr sits at bit 0, the lowest set bit is priority-encoded,
// and the resulting offset is rotated back into a requester index.
module rr_picker
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    localparam logic [IDX_W:0] NUM_EXT = (IDX_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] reqTwice;
    logic [NUM_REQ-1:0]   rotated;
    logic [IDX_W:0]       startRaw;
    logic [IDX_W:0]       startIdx;
    logic [IDX_W:0]       sumRaw;
    logic [IDX_W-1:0]     offset;

    // Rotate, priority-encode from the bottom, then undo the rotation modulo NUM_REQ.
    always_comb begin
        reqTwice = {req, req};
        startRaw = {1'b0, ptr} + (IDX_W+1)'(1);
        startIdx = (startRaw >= NUM_EXT) ? (startRaw - NUM_EXT) : startRaw;
        rotated  = reqTwice[startIdx +: NUM_REQ];
        offset   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
            end
        end
        sumRaw = startIdx + {1'b0, offset};
        winner = IDX_W'((sumRaw >= NUM_EXT) ? (sumRaw - NUM_EXT) : sumRaw);
        found  = |req;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX serializer between NUM_REQ byte
// sources. A byte is accepted with a one-cycle ready, launched with a one-cycle
// tx_start, then the block waits out tx_busy and an optional idle gap.
// Build option: define UART_SCHED_BURST_EN to let the current grantee send up
// to MAX_BURST consecutive bytes before round-robin arbitration resumes.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 0,
    parameter int MAX_BURST  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [idx_w(NUM_REQ)-1:0] grant_id,
    output logic                      active
);

    localparam int               IDX_W     = idx_w(NUM_REQ);
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]       GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || GAP_CYCLES > 255 ||
        MAX_BURST < 1 || MAX_BURST > 16) begin : gBadParams
        $error("uart_tx_scheduler: parameter out of range");
    end

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  grantId_q, grantId_d;
    logic [BYTE_W-1:0] txData_q, txData_d;
    logic [7:0]        gapCnt_q, gapCnt_d;
    logic              txStart_q;
    logic              active_q;
    logic              byteDone;
    logic              pickFound;
    logic [IDX_W-1:0]  pickWinner;
`ifdef UART_SCHED_BURST_EN
    localparam logic [4:0] BURST_LAST = 5'(MAX_BURST - 1);
    logic [4:0] burstCnt_q, burstCnt_d;
`endif

    rr_picker #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) uPicker (
        .req   (req_valid),
        .ptr   (ptr_q),
        .found (pickFound),
        .winner(pickWinner)
    );

    // Next-state and acceptance logic; req_ready is the only combinational output.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grantId_d = grantId_q;
        txData_d  = txData_q;
        gapCnt_d  = gapCnt_q;
        req_ready = '0;
        byteDone  = 1'b0;
`ifdef UART_SCHED_BURST_EN
        burstCnt_d = burstCnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    req_ready[pickWinner] = 1'b1;
                    txData_d  = req_data[pickWinner*BYTE_W +: BYTE_W];
                    grantId_d = pickWinner;
                    ptr_d     = pickWinner;
                    state_d   = LAUNCH;
`ifdef UART_SCHED_BURST_EN
                    burstCnt_d = '0;
`endif
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES > 0) begin
                        gapCnt_d = GAP_LOAD;
                        state_d  = GAP;
                    end else begin
                        byteDone = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gapCnt_q == 8'd0) begin
                    byteDone = 1'b1;
                end else begin
                    gapCnt_d = gapCnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (byteDone) begin
`ifdef UART_SCHED_BURST_EN
            if (req_valid[grantId_q] && (burstCnt_q < BURST_LAST)) begin
                req_ready[grantId_q] = 1'b1;
                txData_d   = req_data[grantId_q*BYTE_W +: BYTE_W];
                burstCnt_d = burstCnt_q + 5'd1;
                state_d    = LAUNCH;
            end else begin
                burstCnt_d = '0;
                state_d    = IDLE;
            end
`else
            state_d = IDLE;
`endif
        end

        if (reset) begin
            req_ready = '0;
        end
    end

    // State, pointer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_RESET;
            grantId_q <= '0;
            txData_q  <= '0;
            gapCnt_q  <= '0;
            txStart_q <= 1'b0;
            active_q  <= 1'b0;
`ifdef UART_SCHED_BURST_EN
            burstCnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grantId_q <= grantId_d;
            txData_q  <= txData_d;
            gapCnt_q  <= gapCnt_d;
            txStart_q <= (state_d == LAUNCH);
            active_q  <= (state_d != IDLE);
`ifdef UART_SCHED_BURST_EN
            burstCnt_q <= burstCnt_d;
`endif
        end
    end

    assign tx_data  = txData_q;
    assign tx_start = txStart_q;
    assign grant_id = grantId_q;
    assign active   = active_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: two instances (no gap, 3-cycle gap) share
// the same requesters, each driving its own serializer model. A cycle-level
// reference model derived from byte-slot timing predicts every output.
module tb_uart_tx_scheduler;

    localparam int N         = 4;
    localparam int MAXB      = 2;
    localparam int GAP0      = 0;
    localparam int GAP1      = 3;
    localparam int BUSY_LEN  = 10;
    localparam int BYTE_SLOT = 3 + BUSY_LEN;

    logic           clk      = 1'b0;
    logic           reset    = 1'b1;
    logic [N-1:0]   reqValid = '0;
    logic [8*N-1:0] reqData  = '0;

    logic [N-1:0] ready0, ready1;
    logic [7:0]   txData0, txData1;
    logic         txStart0, txStart1;
    logic         busy0, busy1;
    logic [1:0]   grant0, grant1;
    logic         active0, active1;
    int           busyCnt0 = 0;
    int           busyCnt1 = 0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit checkEn = 0;
    bit recOn   = 0;
    bit latEn   = 0;
    int accQ0[$];
    int accQ1[$];
    int rrExp[8];
    int burstExp[6];
    int burstLen;
    int waitN;
    logic [7:0] firstByte;

    int mPtr[2], mReadyFrom[2], mBurst[2], mGrant[2], mData[2], fallCyc[2];
    bit mStart[2], mActive[2], prevBusy[2];

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(GAP0), .MAX_BURST(MAXB)) dut0 (
        .clk(clk), .reset(reset), .req_valid(reqValid), .req_data(reqData),
        .req_ready(ready0), .tx_data(txData0), .tx_start(txStart0), .tx_busy(busy0),
        .grant_id(grant0), .active(active0)
    );

    uart_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(GAP1), .MAX_BURST(MAXB)) dut1 (
        .clk(clk), .reset(reset), .req_valid(reqValid), .req_data(reqData),
        .req_ready(ready1), .tx_data(txData1), .tx_start(txStart1), .tx_busy(busy1),
        .grant_id(grant1), .active(active1)
    );

    // Serializer models: busy one cycle after tx_start, for BUSY_LEN cycles.
    always @(posedge clk) begin
        if (reset) busyCnt0 <= 0;
        else if (txStart0) busyCnt0 <= BUSY_LEN;
        else if (busyCnt0 > 0) busyCnt0 <= busyCnt0 - 1;
        if (reset) busyCnt1 <= 0;
        else if (txStart1) busyCnt1 <= BUSY_LEN;
        else if (busyCnt1 > 0) busyCnt1 <= busyCnt1 - 1;
    end
    assign busy0 = (busyCnt0 > 0);
    assign busy1 = (busyCnt1 > 0);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rrPick(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int accAt(input int m, input int i);
        if (m == 0) return (i < accQ0.size()) ? accQ0[i] : -1;
        return (i < accQ1.size()) ? accQ1[i] : -1;
    endfunction

    task automatic modelReset(input int m);
        mData[m]      = 0;
        mGrant[m]     = 0;
        mPtr[m]       = N - 1;
        mStart[m]     = 0;
        mActive[m]    = 0;
        mReadyFrom[m] = cyc + 1;
        mBurst[m]     = 0;
        fallCyc[m]    = -1;
    endtask

    task automatic modelStep(input int m, input logic [N-1:0] rdy, input logic [7:0] dat,
                             input logic st, input logic [1:0] gr, input logic act,
                             input logic bsy);
        int           w;
        int           gap;
        bit           burstAcc;
        logic [N-1:0] expRdy;
        gap      = (m == 0) ? GAP0 : GAP1;
        w        = -1;
        burstAcc = 0;
        expRdy   = '0;
        if (checkEn) begin
            checkOutput($sformatf("txData%0d", m), 32'(dat), 32'(mData[m]));
            checkOutput($sformatf("grant%0d", m), 32'(gr), 32'(mGrant[m]));
            checkOutput($sformatf("txStart%0d", m), 32'(st), 32'(mStart[m]));
            checkOutput($sformatf("active%0d", m), 32'(act), 32'(mActive[m]));
            checkOutput($sformatf("startWhileBusy%0d", m), 32'(st & bsy), 32'd0);
        end
        if (!reset) begin
            if (cyc >= mReadyFrom[m]) begin
                w = rrPick(mPtr[m], reqValid);
            end
`ifdef UART_SCHED_BURST_EN
            else if (cyc == mReadyFrom[m] - 1 && reqValid[mGrant[m]] && mBurst[m] < MAXB - 1) begin
                w        = mGrant[m];
                burstAcc = 1;
            end
`endif
        end
        if (w >= 0) expRdy[w] = 1'b1;
        if (checkEn) checkOutput($sformatf("ready%0d", m), 32'(rdy), 32'(expRdy));

        if (prevBusy[m] && !bsy) fallCyc[m] = cyc;
        if (latEn && rdy != '0 && fallCyc[m] >= 0) begin
            checkOutput($sformatf("gapLatency%0d", m), cyc - fallCyc[m], burstAcc ? gap : gap + 1);
            fallCyc[m] = -1;
        end
        prevBusy[m] = bsy;

        if (recOn) begin
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) begin
                    if (m == 0) accQ0.push_back(i);
                    else accQ1.push_back(i);
                end
            end
        end

        if (reset) begin
            modelReset(m);
        end else if (w >= 0) begin
            mData[m]      = int'(reqData[8*w +: 8]);
            mGrant[m]     = w;
            mPtr[m]       = w;
            mStart[m]     = 1;
            mActive[m]    = 1;
            mReadyFrom[m] = cyc + BYTE_SLOT + gap;
            mBurst[m]     = burstAcc ? mBurst[m] + 1 : 0;
        end else begin
            mStart[m]  = 0;
            mActive[m] = (cyc + 1 < mReadyFrom[m]);
        end
    endtask

    // Reference model and output checks, sampled mid-cycle.
    always @(negedge clk) begin
        modelStep(0, ready0, txData0, txStart0, grant0, active0, busy0);
        modelStep(1, ready1, txData1, txStart1, grant1, active1, busy1);
        cyc++;
    end

    task automatic applyStimulus(input logic [N-1:0] v, input int cycles);
        repeat (cycles) begin
            reqValid = v;
            for (int i = 0; i < N; i++) reqData[8*i +: 8] = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef UART_SCHED_BURST_EN
        rrExp    = '{0, 0, 1, 1, 2, 2, 3, 3};
        burstExp = '{1, 1, 2, 2, 1, 1};
        burstLen = 6;
`else
        rrExp    = '{0, 1, 2, 3, 0, 1, 2, 3};
        burstExp = '{1, 2, 1, 2, 0, 0};
        burstLen = 4;
`endif
        modelReset(0);
        modelReset(1);
        repeat (2) @(posedge clk);
        #1 checkEn = 1;
        @(posedge clk);
        #1;

        // Reset release: requester 0 wins first, launched one cycle later.
        reset    = 1'b0;
        recOn    = 1;
        latEn    = 1;
        fallCyc  = '{-1, -1};
        reqValid = 4'b1111;
        for (int i = 0; i < N; i++) reqData[8*i +: 8] = 8'($urandom_range(0, 255));
        firstByte = reqData[7:0];
        @(negedge clk);
        checkOutput("rstReady0", 32'(ready0), 32'd1);
        checkOutput("rstReady1", 32'(ready1), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) reqData[8*i +: 8] = 8'($urandom_range(0, 255));
        @(negedge clk);
        checkOutput("firstStart", 32'(txStart0), 32'd1);
        checkOutput("firstData", 32'(txData0), 32'(firstByte));
        @(posedge clk);
        #1;

        // Round-robin with all requesters valid.
        applyStimulus(4'b1111, 8 * (BYTE_SLOT + GAP1) + 20);
        latEn = 0;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("rrSeq0_%0d", i), accAt(0, i), rrExp[i]);
            checkOutput($sformatf("rrSeq1_%0d", i), accAt(1, i), rrExp[i]);
        end

        // Skip and wrap around the pointer.
        applyStimulus(4'b0100, 40);
        accQ0.delete();
        accQ1.delete();
        applyStimulus(4'b0011, 40);
        checkOutput("wrapWin0", accAt(0, 0), 0);
        checkOutput("wrapWin1", accAt(1, 0), 0);
        accQ0.delete();
        accQ1.delete();
        applyStimulus(4'b0100, 40);
        checkOutput("skipWin0", accAt(0, 0), 2);
        checkOutput("skipWin1", accAt(1, 0), 2);

        // Random valid/data, including valids dropped before acceptance.
        recOn = 0;
        for (int k = 0; k < 300; k++) applyStimulus(4'($urandom_range(0, 15)), 1);

        // Reset while the first instance waits out tx_busy.
        waitN = 0;
        while (busy0 && waitN < 40) begin
            applyStimulus(4'b1111, 1);
            waitN++;
        end
        checkOutput("busyIdleWait", 32'(busy0), 32'd0);
        waitN = 0;
        while (!busy0 && waitN < 40) begin
            applyStimulus(4'b1111, 1);
            waitN++;
        end
        checkOutput("busyRiseWait", 32'(busy0), 32'd1);
        applyStimulus(4'b1111, 3);
        reset = 1'b1;
        applyStimulus(4'b0000, 1);
        reset    = 1'b0;
        recOn    = 1;
        reqValid = 4'b1111;
        @(negedge clk);
        checkOutput("midRstActive0", 32'(active0), 32'd0);
        checkOutput("midRstActive1", 32'(active1), 32'd0);
        checkOutput("midRstData0", 32'(txData0), 32'd0);
        checkOutput("midRstGrant0", 32'(grant0), 32'd0);
        checkOutput("midRstStart0", 32'(txStart0), 32'd0);
        checkOutput("midRstWin0", 32'(ready0), 32'd1);
        checkOutput("midRstWin1", 32'(ready1), 32'd1);
        @(posedge clk);
        #1;

        // Two requesters held valid: burst behaviour follows the build option.
        accQ0.delete();
        accQ1.delete();
        applyStimulus(4'b0110, 8 * (BYTE_SLOT + GAP1));
        for (int i = 0; i < burstLen; i++) begin
            checkOutput($sformatf("burstSeq0_%0d", i), accAt(0, i), burstExp[i]);
            checkOutput($sformatf("burstSeq1_%0d", i), accAt(1, i), burstExp[i]);
        end

        applyStimulus(4'b0000, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
